gb_wr_sched: RTL and testbench
==============================

GB_WR_SCHED -- requirements
Module: gb_wr_sched

Interface
REQ-001 Parameter CYC_BITWIDTH, default 8, SHALL set the width of the per-requester cycle-count field.
REQ-002 Parameter TIMEOUT_W, default 16, SHALL set the width of the idle-beat timeout counter.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req  input  3  SHALL carry the per-requester load request; index i maps to data type i (2'b00, 2'b01, 2'b10).
REQ-006 cfg_sram_num  input  12  SHALL carry the SRAM count for each requester, 4 bits each; requester i uses [4i+3:4i].
REQ-007 cfg_data_num  input  12  SHALL carry the data count for each requester, 4 bits each, with the same packing as cfg_sram_num.
REQ-008 cfg_cyc_num  input  3*CYC_BITWIDTH  SHALL carry the cycle count for each requester, packed the same way.
REQ-009 src_vld  input  3  SHALL be the per-requester data-beat valid.
REQ-010 src_rdy  output  3  SHALL be the per-requester data-beat ready.
REQ-011 grant  output  3  SHALL be the one-hot current owner; 0 when idle.
REQ-012 ack  output  3  SHALL pulse for one cycle to mark job completion or abort.
REQ-013 wid_start  output  1  SHALL be the one-cycle start pulse to the write-ID generator.
REQ-014 wid_data_type  output  2  SHALL be the owner's data type.
REQ-015 wid_sram_num, wid_data_num  output  4 each  SHALL be the latched configuration for the generator.
REQ-016 wid_cyc_num  output  CYC_BITWIDTH  SHALL be the latched cycle count for the generator.
REQ-017 wid_read_out_flag  output  1  SHALL be the beat strobe to the generator.
REQ-018 wid_done  input  1  SHALL be the registered done from the generator.
REQ-019 busy  output  1  SHALL be high in any state other than IDLE.
REQ-020 beat_cnt  output  16  SHALL be the number of beats accepted in the current or last job.
REQ-021 err_cfg, err_timeout  output  1 each  SHALL be sticky error flags.

Function
REQ-022 The FSM SHALL have five states: IDLE, GRANT, START, RUN, ACK.
REQ-023 IDLE: when any req is high, the FSM SHALL pick the winner round-robin starting at rr_ptr (reset value 0) and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-024 GRANT: the FSM SHALL assert grant, latch the winner's cfg fields into the wid_* registers, and clear beat_cnt; if the latched data_num==0 or cyc_num==0 it SHALL set err_cfg and go to ACK, otherwise go to START.
REQ-025 START: wid_start SHALL be high for exactly one cycle, and the FSM SHALL then go to RUN.
REQ-026 RUN: src_rdy[g] SHALL equal 1 & ~done_q, where g is the granted index; all other src_rdy bits SHALL be 0.
REQ-027 RUN: wid_read_out_flag SHALL equal src_vld[g] & src_rdy[g] (combinational), and each such beat SHALL increment beat_cnt, saturating at 16'hFFFF.
REQ-028 done_q SHALL equal wid_done & (beat_cnt != 0), so that the stale done the generator holds before its first post-start beat is ignored.
REQ-029 RUN: when done_q is high, the FSM SHALL go to ACK, and no beat SHALL be accepted in that cycle.
REQ-030 RUN: a TIMEOUT_W-bit counter SHALL clear on each beat and increment otherwise.
REQ-031 RUN: when the timeout counter reaches all-ones, the FSM SHALL set err_timeout and go to ACK.
REQ-032 ACK: ack[g] SHALL pulse for one cycle, rr_ptr SHALL become (g+1) mod 3, grant SHALL clear, and the FSM SHALL return to IDLE.
REQ-033 req deasserted while the FSM is past IDLE SHALL NOT abort the job.
REQ-034 A requester SHALL NOT be re-granted before it has seen its own ack.
REQ-035 wid_data_type, wid_sram_num, wid_data_num and wid_cyc_num SHALL hold their values from GRANT until the next GRANT.
REQ-036 Minimum job latency SHALL be 4 cycles from IDLE sampling req to the ack pulse, plus the beats accepted.

Reset
REQ-037 When rst is high at a clock edge, the FSM SHALL go to IDLE and rr_ptr and all counters SHALL clear to 0.
REQ-038 When rst is high at a clock edge, every output SHALL be driven to 0, including err_cfg and err_timeout.
REQ-039 A reset taken mid-job SHALL abandon the job with no ack pulse.
REQ-040 The first grant after reset SHALL go to requester 0 if it is requesting.

Verification
REQ-041 req=3'b010, cfg1 = sram 4 / data 3 / cyc 1, src_vld[1] held high, wid_done rises after 3 beats -> wid_start pulses once, wid_data_type=2'b01, exactly 3 wid_read_out_flag, ack=3'b010 one cycle, beat_cnt=3.
REQ-042 req=3'b111 held through 4 jobs -> grant order 0,1,2,0.
REQ-043 wid_done held high from START while src_vld[0] stays low for 5 cycles -> the FSM stays in RUN with no ack; after the first beat, ack follows done.
REQ-044 cfg_cyc_num=0 for requester 2 -> no wid_start, ack=3'b100, err_cfg=1 and stays set.
REQ-045 TIMEOUT_W=4, RUN with no src_vld -> err_timeout=1 after 15 idle cycles, followed by an ack pulse.
REQ-046 rst asserted in RUN after 2 beats -> next cycle grant=0, busy=0, beat_cnt=0, and no ack pulse.

Source files
------------

// File: rtl/gb_wr_sched_if.sv
// Bundle of request, config, data-beat and write-ID generator signals for gb_wr_sched.
// The slave modport is the scheduler side; master is the requester/generator side.
interface gb_wr_sched_if #(
  parameter int CYC_BITWIDTH = 8
);
  logic [2:0]                  req;
  logic [11:0]                 cfg_sram_num;
  logic [11:0]                 cfg_data_num;
  logic [3*CYC_BITWIDTH-1:0]   cfg_cyc_num;
  logic [2:0]                  src_vld;
  logic [2:0]                  src_rdy;
  logic [2:0]                  grant;
  logic [2:0]                  ack;
  logic                        wid_start;
  logic [1:0]                  wid_data_type;
  logic [3:0]                  wid_sram_num;
  logic [3:0]                  wid_data_num;
  logic [CYC_BITWIDTH-1:0]     wid_cyc_num;
  logic                        wid_read_out_flag;
  logic                        wid_done;
  logic                        busy;
  logic [15:0]                 beat_cnt;
  logic                        err_cfg;
  logic                        err_timeout;

  modport master (
    output req, cfg_sram_num, cfg_data_num, cfg_cyc_num, src_vld, wid_done,
    input  src_rdy, grant, ack, wid_start, wid_data_type, wid_sram_num,
           wid_data_num, wid_cyc_num, wid_read_out_flag, busy, beat_cnt,
           err_cfg, err_timeout
  );

  modport slave (
    input  req, cfg_sram_num, cfg_data_num, cfg_cyc_num, src_vld, wid_done,
    output src_rdy, grant, ack, wid_start, wid_data_type, wid_sram_num,
           wid_data_num, wid_cyc_num, wid_read_out_flag, busy, beat_cnt,
           err_cfg, err_timeout
  );
endinterface

// File: rtl/gb_wr_sched.sv
// Round-robin write scheduler: grants one of three requesters, hands its config to the
// write-ID generator, streams data beats until the generator reports done, then acks.
module gb_wr_sched #(
  parameter int CYC_BITWIDTH = 8,
  parameter int TIMEOUT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  gb_wr_sched_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] ACK   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic [1:0]              rr_q, rr_d;
  logic [2:0]              grant_q, grant_d;
  logic [1:0]              dtype_q, dtype_d;
  logic [3:0]              sram_q, sram_d;
  logic [3:0]              data_q, data_d;
  logic [CYC_BITWIDTH-1:0] cyc_q, cyc_d;
  logic [15:0]             beat_cnt_q, beat_cnt_d;
  logic [TIMEOUT_W-1:0]    tmo_q, tmo_d;
  logic                    err_cfg_q, err_cfg_d;
  logic                    err_tmo_q, err_tmo_d;

  logic [3:0]              sram_arr [3];
  logic [3:0]              data_arr [3];
  logic [CYC_BITWIDTH-1:0] cyc_arr  [3];
  logic [2:0]              src_rdy_w;
  logic                    done_valid;
  logic                    run_rdy;
  logic                    beat;
  logic [1:0]              rr_idx1, rr_idx2;
  logic [1:0]              win_idx;

  // The generator holds done from its previous job until it sees a beat of the new one.
  assign done_valid = bus.wid_done & (beat_cnt_q != 16'd0);
  assign run_rdy    = (state_q == RUN) & ~done_valid;
  assign beat       = run_rdy & bus.src_vld[owner_q];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_req
      assign sram_arr[gi]  = bus.cfg_sram_num[4*gi +: 4];
      assign data_arr[gi]  = bus.cfg_data_num[4*gi +: 4];
      assign cyc_arr[gi]   = bus.cfg_cyc_num[CYC_BITWIDTH*gi +: CYC_BITWIDTH];
      assign src_rdy_w[gi] = run_rdy & (owner_q == 2'(gi));
    end
  endgenerate

  assign rr_idx1 = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
  assign rr_idx2 = (rr_q == 2'd0) ? 2'd2 : rr_q - 2'd1;

  always_comb begin
    win_idx = rr_q;
    if (bus.req[rr_q])         win_idx = rr_q;
    else if (bus.req[rr_idx1]) win_idx = rr_idx1;
    else if (bus.req[rr_idx2]) win_idx = rr_idx2;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    dtype_d    = dtype_q;
    sram_d     = sram_q;
    data_d     = data_q;
    cyc_d      = cyc_q;
    beat_cnt_d = beat_cnt_q;
    tmo_d      = tmo_q;
    err_cfg_d  = err_cfg_q;
    err_tmo_d  = err_tmo_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = win_idx;
          grant_d = 3'b001 << win_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        dtype_d    = owner_q;
        sram_d     = sram_arr[owner_q];
        data_d     = data_arr[owner_q];
        cyc_d      = cyc_arr[owner_q];
        beat_cnt_d = 16'd0;
        tmo_d      = '0;
        if (data_arr[owner_q] == 4'd0 || cyc_arr[owner_q] == '0) begin
          err_cfg_d = 1'b1;
          state_d   = ACK;
        end else begin
          state_d = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (done_valid) begin
          state_d = ACK;
        end else if (beat) begin
          beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
          tmo_d      = '0;
        end else if (tmo_q == {TIMEOUT_W{1'b1}}) begin
          err_tmo_d = 1'b1;
          state_d   = ACK;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ACK: begin
        grant_d = 3'b000;
        rr_d    = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      rr_q       <= 2'd0;
      grant_q    <= 3'd0;
      dtype_q    <= 2'd0;
      sram_q     <= 4'd0;
      data_q     <= 4'd0;
      cyc_q      <= '0;
      beat_cnt_q <= 16'd0;
      tmo_q      <= '0;
      err_cfg_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      dtype_q    <= dtype_d;
      sram_q     <= sram_d;
      data_q     <= data_d;
      cyc_q      <= cyc_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_q      <= tmo_d;
      err_cfg_q  <= err_cfg_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  assign bus.src_rdy           = src_rdy_w;
  assign bus.grant             = grant_q;
  assign bus.ack               = (state_q == ACK) ? grant_q : 3'b000;
  assign bus.wid_start         = (state_q == START);
  assign bus.wid_data_type     = dtype_q;
  assign bus.wid_sram_num      = sram_q;
  assign bus.wid_data_num      = data_q;
  assign bus.wid_cyc_num       = cyc_q;
  assign bus.wid_read_out_flag = beat;
  assign bus.busy              = (state_q != IDLE);
  assign bus.beat_cnt          = beat_cnt_q;
  assign bus.err_cfg           = err_cfg_q;
  assign bus.err_timeout       = err_tmo_q;

endmodule

// File: tb/tb_gb_wr_sched.sv
// Directed bench for gb_wr_sched: a job table for grant order and per-job results,
// plus hand sequences for stale done, idle timeout and mid-job reset.
module tb_gb_wr_sched;

  logic clk = 1'b0;
  logic rst;
  logic force_done;
  logic gen_done;
  int   gen_cnt;
  int   gen_target;
  int   n_checks = 0;
  int   n_fail   = 0;

  gb_wr_sched_if #(.CYC_BITWIDTH(8)) bus ();

  gb_wr_sched #(.CYC_BITWIDTH(8), .TIMEOUT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Generator model: done rises on the gen_target-th beat and is held until the next beat.
  assign bus.wid_done = force_done | gen_done;
  always @(posedge clk) begin
    if (rst) begin
      gen_done <= 1'b0;
      gen_cnt  <= 0;
    end else if (bus.wid_start) begin
      gen_cnt <= 0;
    end else if (bus.wid_read_out_flag) begin
      gen_cnt  <= gen_cnt + 1;
      gen_done <= (gen_cnt + 1 >= gen_target);
    end
  end

  typedef struct {
    logic [2:0] req;
    logic [7:0] cyc2;
    int         target;
    logic [2:0] exp_grant;
    logic [1:0] exp_dtype;
    logic [3:0] exp_sram;
    int         exp_starts;
    int         exp_flags;
    int         exp_lat;
    logic       exp_err_cfg;
  } job_t;

  job_t jobs [9];
  job_t post_rst_job;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_job(input job_t j, input string nm);
    logic [2:0]  g_seen;
    logic [2:0]  a_seen;
    logic [1:0]  dt;
    logic [3:0]  sr;
    logic [15:0] bc;
    logic        ec;
    int          starts;
    int          flags;
    int          lat;
    bit          got;
    g_seen = 3'b0; a_seen = 3'b0; dt = 2'b0; sr = 4'b0; bc = 16'b0; ec = 1'b0;
    starts = 0; flags = 0; lat = -1; got = 1'b0;
    @(posedge clk); #1;
    bus.req         = j.req;
    bus.cfg_cyc_num = {j.cyc2, 8'd1, 8'd7};
    bus.src_vld     = 3'b111;
    gen_target      = j.target;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (g_seen == 3'b0) g_seen = bus.grant;
      starts += int'(bus.wid_start);
      flags  += int'(bus.wid_read_out_flag);
      if (bus.ack != 3'b0) begin
        got    = 1'b1;
        a_seen = bus.ack;
        lat    = k;
        dt     = bus.wid_data_type;
        sr     = bus.wid_sram_num;
        bc     = bus.beat_cnt;
        ec     = bus.err_cfg;
      end
    end
    chk({nm, "_acked"}, 32'(got), 32'd1);
    chk({nm, "_grant"}, 32'(g_seen), 32'(j.exp_grant));
    chk({nm, "_ack"}, 32'(a_seen), 32'(j.exp_grant));
    chk({nm, "_dtype"}, 32'(dt), 32'(j.exp_dtype));
    chk({nm, "_sram"}, 32'(sr), 32'(j.exp_sram));
    chk({nm, "_starts"}, 32'(starts), 32'(j.exp_starts));
    chk({nm, "_flags"}, 32'(flags), 32'(j.exp_flags));
    chk({nm, "_latency"}, 32'(lat), 32'(j.exp_lat));
    chk({nm, "_beat_cnt"}, 32'(bc), 32'(j.exp_flags));
    chk({nm, "_err_cfg"}, 32'(ec), 32'(j.exp_err_cfg));
    $display("job %s: grant=%b ack=%b dtype=%0d sram=%0d starts=%0d beats=%0d latency=%0d err_cfg=%b",
             nm, g_seen, a_seen, dt, sr, starts, flags, lat, ec);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.wid_start) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    //          req     cyc2  tgt grant   dt    sram  st fl lat err
    jobs[0] = '{3'b111, 8'd5, 2, 3'b001, 2'd0, 4'd2, 1, 2, 6, 1'b0};
    jobs[1] = '{3'b111, 8'd5, 2, 3'b010, 2'd1, 4'd4, 1, 2, 6, 1'b0};
    jobs[2] = '{3'b111, 8'd5, 2, 3'b100, 2'd2, 4'd9, 1, 2, 6, 1'b0};
    jobs[3] = '{3'b111, 8'd5, 2, 3'b001, 2'd0, 4'd2, 1, 2, 6, 1'b0};
    jobs[4] = '{3'b010, 8'd5, 3, 3'b010, 2'd1, 4'd4, 1, 3, 7, 1'b0};
    jobs[5] = '{3'b100, 8'd0, 3, 3'b100, 2'd2, 4'd9, 0, 0, 2, 1'b1};
    jobs[6] = '{3'b101, 8'd5, 1, 3'b001, 2'd0, 4'd2, 1, 1, 5, 1'b1};
    jobs[7] = '{3'b101, 8'd5, 2, 3'b100, 2'd2, 4'd9, 1, 2, 6, 1'b1};
    jobs[8] = '{3'b110, 8'd5, 2, 3'b010, 2'd1, 4'd4, 1, 2, 6, 1'b1};
    post_rst_job = '{3'b111, 8'd5, 1, 3'b001, 2'd0, 4'd2, 1, 1, 5, 1'b0};

    rst = 1'b1;
    force_done = 1'b0;
    gen_target = 100;
    bus.req = 3'b0;
    bus.src_vld = 3'b0;
    bus.cfg_sram_num = {4'd9, 4'd4, 4'd2};
    bus.cfg_data_num = {4'd6, 4'd3, 4'd5};
    bus.cfg_cyc_num  = {8'd5, 8'd1, 8'd7};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_handshake", {29'b0, bus.grant}, 32'd0);
    chk("rst_status", {bus.busy, bus.ack, bus.src_rdy, bus.wid_start, bus.wid_read_out_flag,
                       bus.err_cfg, bus.err_timeout}, 32'd0);
    chk("rst_wid_regs", {bus.wid_data_type, bus.wid_sram_num, bus.wid_data_num, bus.wid_cyc_num}, 32'd0);
    chk("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
    $display("reset: grant=%b busy=%b beat_cnt=%0d", bus.grant, bus.busy, bus.beat_cnt);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_job(jobs[i], $sformatf("job%0d", i));

    // Stale done held from START is ignored until the first beat lands.
    @(posedge clk); #1;
    bus.req = 3'b001; bus.src_vld = 3'b000; force_done = 1'b1; gen_target = 100;
    wait_start(ok);
    chk("stale_start_seen", 32'(ok), 32'd1);
    bus.req = 3'b000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stale_hold", {25'b0, bus.ack, bus.wid_read_out_flag, bus.src_rdy}, {25'b0, 3'b000, 1'b0, 3'b001});
    end
    @(posedge clk); #1;
    bus.src_vld = 3'b001;
    @(negedge clk);
    chk("stale_first_beat", {28'b0, bus.wid_read_out_flag, bus.src_rdy}, {28'b0, 1'b1, 3'b001});
    @(negedge clk);
    chk("stale_done_blocks_beat", {25'b0, bus.wid_read_out_flag, bus.src_rdy, bus.ack}, 32'd0);
    @(negedge clk);
    chk("stale_ack", 32'(bus.ack), 32'b001);
    chk("stale_beat_cnt", 32'(bus.beat_cnt), 32'd1);
    $display("stale done: ack=%b beat_cnt=%0d", bus.ack, bus.beat_cnt);
    @(posedge clk); #1;
    force_done = 1'b0; bus.src_vld = 3'b000;

    // Idle timeout with TIMEOUT_W=4; req dropped after start must not abort the job.
    bus.req = 3'b010;
    wait_start(ok);
    chk("tmo_start_seen", 32'(ok), 32'd1);
    bus.req = 3'b000;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("tmo_run_wait", {24'b0, bus.ack, bus.err_timeout, bus.src_rdy, bus.busy},
          {24'b0, 3'b000, 1'b0, 3'b010, 1'b1});
    end
    @(negedge clk);
    chk("tmo_fire", {28'b0, bus.err_timeout, bus.ack}, {28'b0, 1'b1, 3'b010});
    @(negedge clk);
    chk("tmo_sticky", {26'b0, bus.err_timeout, bus.err_cfg, bus.ack, bus.busy},
        {26'b0, 1'b1, 1'b1, 3'b000, 1'b0});
    $display("timeout: err_timeout=%b err_cfg=%b busy=%b", bus.err_timeout, bus.err_cfg, bus.busy);

    // Reset taken in RUN after two beats.
    @(posedge clk); #1;
    bus.req = 3'b001; bus.src_vld = 3'b001; gen_target = 100;
    wait_start(ok);
    chk("rrst_start_seen", 32'(ok), 32'd1);
    bus.req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; bus.src_vld = 3'b000;
    @(negedge clk);
    chk("rrst_pre_cnt", 32'(bus.beat_cnt), 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rrst_cleared", {10'b0, bus.grant, bus.busy, bus.beat_cnt, bus.err_cfg, bus.err_timeout}, 32'd0);
    chk("rrst_no_ack", 32'(bus.ack), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rrst_stays_idle", {28'b0, bus.ack, bus.busy}, 32'd0);
    end
    $display("mid-job reset: grant=%b busy=%b beat_cnt=%0d", bus.grant, bus.busy, bus.beat_cnt);

    run_job(post_rst_job, "post_rst");
    @(negedge clk);
    chk("post_rst_ack_width", 32'(bus.ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
